// File: rtl/mem_initiator_if.sv
// Bundles the signals that pass between mem_initiator and its neighbours.
// The core side is the req/rsp handshake and the memory side is the mem_itf bus.
// The master modport is the view from mem_initiator.
// The slave modport is the view from the core and the memory.
interface mem_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;

    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    modport master (
        input  req_valid, req_write, req_addr, req_wmask, req_wdata,
        output req_ready,
        output rsp_valid, rsp_write, rsp_rdata,
        output mem_read, mem_write, mem_addr, mem_wmask, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wmask, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_write, rsp_rdata,
        input  mem_read, mem_write, mem_addr, mem_wmask, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/mem_initiator.sv
// Requester-side driver for the mem_itf read/write/resp protocol.
// Core requests are buffered in a small FIFO and issued one at a time.
// All memory bus signals are held stable until mem_resp.
// Each completion produces a one-cycle response pulse to the core.
// A stuck memory raises a sticky timeout flag, but the transaction is never aborted.
module mem_initiator #(
    parameter int QUEUE_DEPTH = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic              clk,
    input  logic              rst,
    mem_initiator_if.master   bus,
    output logic              timeout_err
);

    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [PW-1:0] LAST_PTR = PW'(QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(QUEUE_DEPTH);
    localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

    typedef struct packed {
        logic        write;
        logic [29:0] word;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } req_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    req_t          fifo_mem [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    logic [TW-1:0] wait_cnt;

    req_t in_req;
    req_t head;
    logic push;
    logic pop;
    logic unused_addr_bits;

    // Readiness uses only the registered occupancy, so a pop on the same edge does not free a slot.
    assign bus.req_ready = (count < FULL_CNT);
    assign push          = bus.req_valid && bus.req_ready;
    // The head is issued from IDLE, and also at the single exit edge of GAP.
    assign pop           = (state != BUSY) && (count != '0);
    assign head          = fifo_mem[rd_ptr];

    assign in_req.write = bus.req_write;
    assign in_req.word  = bus.req_addr[31:2];
    assign in_req.wmask = bus.req_wmask;
    assign in_req.wdata = bus.req_wdata;

    // The byte offset is dropped, because the bus is word-aligned.
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // Request storage. The payload needs no reset, because the count decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_req;
        end
    end

    // Pointers wrap explicitly at the last entry, so any depth stays in range.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Issue/complete FSM. It owns every registered bus output, the response pulse and the stall watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wmask <= '0;
            bus.mem_wdata <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
            wait_cnt      <= '0;
            timeout_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pop) begin
                        state         <= BUSY;
                        bus.mem_read  <= ~head.write;
                        bus.mem_write <= head.write;
                        bus.mem_addr  <= {head.word, 2'b00};
                        bus.mem_wmask <= head.write ? head.wmask : 4'b0000;
                        bus.mem_wdata <= head.write ? head.wdata : 32'h0;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (bus.mem_resp) begin
                        state         <= GAP;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        bus.mem_wmask <= 4'b0000;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_write <= bus.mem_write;
                        bus.rsp_rdata <= bus.mem_write ? 32'h0 : bus.mem_rdata;
                        wait_cnt      <= '0;
                    end else if (TIMEOUT != 0) begin
                        if (wait_cnt != TMAX) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                        if (wait_cnt == TMAX - 1'b1) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_initiator.sv
// Directed testbench for mem_initiator.
// It uses a behavioural mem_itf memory, a bus monitor and per-scenario tasks.
module tb_mem_initiator;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timeout_err;

    mem_initiator_if bus();

    mem_initiator #(
        .QUEUE_DEPTH (2),
        .TIMEOUT     (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        bit          write;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];
    int  mem_delay    = 3;
    bit  mem_stall    = 1'b0;
    bit  rand_delay   = 1'b0;
    bit  mon_en       = 1'b0;
    bit  stalled_seen = 1'b0;

    // Edge counter: holds the index of the most recent rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural memory. It latches the strobe one edge late, waits cur_delay cycles,
    // then raises resp for one cycle and performs the access.
    int          wait_ctr = 0;
    int          cur_delay = 0;
    logic [9:0]  idx;
    always @(negedge clk) begin
        if (rst || !(bus.mem_read || bus.mem_write)) begin
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 32'hBAD0_BAD0;
            wait_ctr      = 0;
        end else if (bus.mem_resp) begin
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = 32'hBAD0_BAD0;
        end else begin
            if (wait_ctr == 0) cur_delay = rand_delay ? $urandom_range(0, 4) : mem_delay;
            wait_ctr++;
            if (!mem_stall && wait_ctr >= cur_delay + 2) begin
                idx = bus.mem_addr[11:2];
                if (bus.mem_write) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_wmask[b]) mem[idx][8*b +: 8] = bus.mem_wdata[8*b +: 8];
                    bus.mem_rdata = 32'hBAD0_BAD0;
                end else begin
                    bus.mem_rdata = mem[idx];
                end
                bus.mem_resp = 1'b1;
            end
        end
    end

    // Bus monitor. It runs just after each edge, checks protocol rules and records issues and responses.
    logic        prev_stro = 1'b0;
    logic        prev_rsp  = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_mask;
    logic        prev_rd, prev_wr;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            prev_stro = 1'b0;
            prev_rsp  = 1'b0;
        end else begin
            if (mon_en) begin
                checks++;
                if ($isunknown({bus.mem_read, bus.mem_write, bus.rsp_valid, bus.req_ready, timeout_err, bus.mem_addr, bus.mem_wmask})) begin
                    errors++;
                    $display("[TB] FAIL proto_x: cyc %0d read=%b write=%b rsp_valid=%b ready=%b, required no X", cyc, bus.mem_read, bus.mem_write, bus.rsp_valid, bus.req_ready);
                end
                checks++;
                if ((bus.mem_read && bus.mem_write) !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL proto_rw: cyc %0d read=%b write=%b, required not both", cyc, bus.mem_read, bus.mem_write);
                end
                if (prev_stro && !bus.mem_resp) begin
                    checks++;
                    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wmask, bus.mem_wdata} !== {prev_rd, prev_wr, prev_addr, prev_mask, prev_wdata}) begin
                        errors++;
                        $display("[TB] FAIL proto_hold: cyc %0d got r%b w%b a=%h m=%h d=%h, required r%b w%b a=%h m=%h d=%h", cyc, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wmask, bus.mem_wdata, prev_rd, prev_wr, prev_addr, prev_mask, prev_wdata);
                    end
                end
                if (prev_rsp) begin
                    checks++;
                    if (bus.rsp_valid !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL rsp_pulse: cyc %0d rsp_valid=%b, required 0 after one-cycle pulse", cyc, bus.rsp_valid);
                    end
                end
            end
            if ((bus.mem_read || bus.mem_write) && !prev_stro)
                iss_q.push_back('{bus.mem_write, bus.mem_addr, bus.mem_wmask, bus.mem_wdata, cyc});
            if (bus.rsp_valid === 1'b1)
                rsp_q.push_back('{bus.rsp_write, bus.rsp_rdata, cyc});
            prev_stro  = bus.mem_read || bus.mem_write;
            prev_rd    = bus.mem_read;
            prev_wr    = bus.mem_write;
            prev_addr  = bus.mem_addr;
            prev_mask  = bus.mem_wmask;
            prev_wdata = bus.mem_wdata;
            prev_rsp   = bus.rsp_valid;
        end
    end

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // Presents one request from a negedge and holds it until accepted; returns at the negedge after the accept edge
    task automatic send_req(input bit w, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d, output int acc_cyc);
        int guard;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wmask = m;
        bus.req_wdata = d;
        while (bus.req_ready !== 1'b1 && guard < 100) begin
            stalled_seen = 1'b1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_accept: req_ready=%b for 100 cycles, required 1", bus.req_ready);
        end
        @(negedge clk);
        acc_cyc = cyc;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        mem_stall = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        iss_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 10;
        if (bus.req_ready !== 1'b1)   begin errors++; $display("[TB] FAIL rst_ready: got %b, required 1", bus.req_ready); end
        if (bus.mem_read !== 1'b0)    begin errors++; $display("[TB] FAIL rst_read: got %b, required 0", bus.mem_read); end
        if (bus.mem_write !== 1'b0)   begin errors++; $display("[TB] FAIL rst_write: got %b, required 0", bus.mem_write); end
        if (bus.mem_addr !== 32'h0)   begin errors++; $display("[TB] FAIL rst_addr: got %h, required 0", bus.mem_addr); end
        if (bus.mem_wmask !== 4'h0)   begin errors++; $display("[TB] FAIL rst_wmask: got %h, required 0", bus.mem_wmask); end
        if (bus.mem_wdata !== 32'h0)  begin errors++; $display("[TB] FAIL rst_wdata: got %h, required 0", bus.mem_wdata); end
        if (bus.rsp_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); end
        if (bus.rsp_write !== 1'b0)   begin errors++; $display("[TB] FAIL rst_rsp_write: got %b, required 0", bus.rsp_write); end
        if (bus.rsp_rdata !== 32'h0)  begin errors++; $display("[TB] FAIL rst_rsp_rdata: got %h, required 0", bus.rsp_rdata); end
        if (timeout_err !== 1'b0)     begin errors++; $display("[TB] FAIL rst_timeout: got %b, required 0", timeout_err); end
        rst = 1'b0;
        mon_en = 1'b1;
        iss_q.delete();
        rsp_q.delete();
    endtask

    task automatic test_read();
        int e;
        mem[64] = 32'hDEADBEEF;
        mem_delay = 3;
        iss_q.delete();
        rsp_q.delete();
        send_req(1'b0, 32'h102, 4'hF, 32'h12345678, e);
        wait_rsp(1, 30);
        repeat (2) @(negedge clk);
        checks++;
        if (iss_q.size() !== 1 || rsp_q.size() !== 1) begin
            errors++;
            $display("[TB] FAIL read_count: got %0d issues %0d responses, required 1 and 1", iss_q.size(), rsp_q.size());
        end else begin
            checks += 6;
            if (iss_q[0].cyc !== e + 1)        begin errors++; $display("[TB] FAIL read_issue_cyc: got %0d, required %0d", iss_q[0].cyc, e + 1); end
            if (iss_q[0].addr !== 32'h100 || iss_q[0].write !== 1'b0) begin errors++; $display("[TB] FAIL read_issue: got addr %h write %b, required 100 and 0", iss_q[0].addr, iss_q[0].write); end
            if (iss_q[0].wmask !== 4'h0)       begin errors++; $display("[TB] FAIL read_wmask: got %h, required 0", iss_q[0].wmask); end
            if (rsp_q[0].cyc !== e + 6)        begin errors++; $display("[TB] FAIL read_rsp_cyc: got %0d, required %0d", rsp_q[0].cyc, e + 6); end
            if (rsp_q[0].rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL read_rdata: got %h, required deadbeef", rsp_q[0].rdata); end
            if (rsp_q[0].write !== 1'b0)       begin errors++; $display("[TB] FAIL read_rsp_write: got %b, required 0", rsp_q[0].write); end
        end
    endtask

    task automatic test_write_read();
        int e0, e1;
        mem[128] = 32'h11223344;
        mem_delay = 2;
        iss_q.delete();
        rsp_q.delete();
        send_req(1'b1, 32'h200, 4'b0101, 32'hAABBCCDD, e0);
        send_req(1'b0, 32'h200, 4'hF, 32'h0, e1);
        wait_rsp(2, 40);
        repeat (2) @(negedge clk);
        checks++;
        if (iss_q.size() !== 2 || rsp_q.size() !== 2) begin
            errors++;
            $display("[TB] FAIL wr_count: got %0d issues %0d responses, required 2 and 2", iss_q.size(), rsp_q.size());
        end else begin
            checks += 6;
            if (iss_q[0].write !== 1'b1 || iss_q[0].addr !== 32'h200 || iss_q[0].wmask !== 4'b0101 || iss_q[0].wdata !== 32'hAABBCCDD) begin
                errors++;
                $display("[TB] FAIL wr_issue: got w%b a=%h m=%h d=%h, required w1 a=200 m=5 d=aabbccdd", iss_q[0].write, iss_q[0].addr, iss_q[0].wmask, iss_q[0].wdata);
            end
            if (rsp_q[0].write !== 1'b1 || rsp_q[0].rdata !== 32'h0) begin errors++; $display("[TB] FAIL wr_rsp: got w%b d=%h, required w1 d=0", rsp_q[0].write, rsp_q[0].rdata); end
            if (rsp_q[1].write !== 1'b0 || rsp_q[1].rdata !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL rd_after_wr: got w%b d=%h, required w0 d=11bb33dd", rsp_q[1].write, rsp_q[1].rdata); end
            if (iss_q[1].cyc !== rsp_q[0].cyc + 1) begin errors++; $display("[TB] FAIL wr_gap: next issue cyc %0d, required %0d", iss_q[1].cyc, rsp_q[0].cyc + 1); end
            if (mem[128] !== 32'h11BB33DD) begin errors++; $display("[TB] FAIL wr_mem: got %h, required 11bb33dd", mem[128]); end
            if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_timeout: got %b, required 0", timeout_err); end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        bit          exp_w [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] exp_a [4] = '{32'h300, 32'h300, 32'h304, 32'h304};
        logic [31:0] exp_d [4] = '{32'h0, 32'hCAFE0001, 32'h0, 32'hBEEF0304};
        mem[193] = 32'h01020304;
        mem_delay = 1;
        stalled_seen = 1'b0;
        iss_q.delete();
        rsp_q.delete();
        send_req(1'b1, 32'h300, 4'hF, 32'hCAFE0001, e);
        send_req(1'b0, 32'h300, 4'hF, 32'h0, e);
        send_req(1'b1, 32'h304, 4'b1100, 32'hBEEF0000, e);
        checks++;
        if (bus.req_ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full: req_ready=%b with 2 queued, required 0", bus.req_ready); end
        send_req(1'b0, 32'h304, 4'hF, 32'h0, e);
        checks++;
        if (stalled_seen !== 1'b1) begin errors++; $display("[TB] FAIL b2b_stall: stalled=%b, required 1", stalled_seen); end
        wait_rsp(4, 80);
        repeat (2) @(negedge clk);
        checks++;
        if (iss_q.size() !== 4 || rsp_q.size() !== 4) begin
            errors++;
            $display("[TB] FAIL b2b_count: got %0d issues %0d responses, required 4 and 4", iss_q.size(), rsp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks += 2;
                if (iss_q[i].write !== exp_w[i] || iss_q[i].addr !== exp_a[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_issue%0d: got w%b a=%h, required w%b a=%h", i, iss_q[i].write, iss_q[i].addr, exp_w[i], exp_a[i]);
                end
                if (rsp_q[i].write !== exp_w[i] || rsp_q[i].rdata !== exp_d[i]) begin
                    errors++;
                    $display("[TB] FAIL b2b_rsp%0d: got w%b d=%h, required w%b d=%h", i, rsp_q[i].write, rsp_q[i].rdata, exp_w[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int e;
        mem_stall = 1'b1;
        iss_q.delete();
        rsp_q.delete();
        send_req(1'b0, 32'h400, 4'hF, 32'h0, e);
        repeat (8) @(negedge clk);
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL stall_early: cyc %0d timeout_err=%b, required 0", cyc, timeout_err); end
        @(negedge clk);
        checks += 2;
        if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL stall_set: cyc %0d timeout_err=%b, required 1", cyc, timeout_err); end
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h400) begin errors++; $display("[TB] FAIL stall_bus: read=%b addr=%h, required 1 and 400", bus.mem_read, bus.mem_addr); end
        repeat (11) @(negedge clk);
        checks += 3;
        if (timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL stall_sticky: timeout_err=%b, required 1", timeout_err); end
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h400) begin errors++; $display("[TB] FAIL stall_hold: read=%b addr=%h, required 1 and 400", bus.mem_read, bus.mem_addr); end
        if (rsp_q.size() !== 0) begin errors++; $display("[TB] FAIL stall_rsp: got %0d responses, required 0", rsp_q.size()); end
    endtask

    task automatic test_reset_mid_write();
        int e;
        do_reset();
        checks++;
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rmw_clear: timeout_err=%b, required 0", timeout_err); end
        mem[320] = 32'h55555555;
        mem_delay = 6;
        send_req(1'b1, 32'h500, 4'hF, 32'h99999999, e);
        send_req(1'b0, 32'h504, 4'hF, 32'h0, e);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 3;
        if (bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rmw_write: got %b, required 0", bus.mem_write); end
        if (bus.req_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmw_ready: got %b, required 1", bus.req_ready); end
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmw_rsp_valid: got %b, required 0", bus.rsp_valid); end
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks += 4;
        if (rsp_q.size() !== 0) begin errors++; $display("[TB] FAIL rmw_rsp: got %0d responses, required 0", rsp_q.size()); end
        if (iss_q.size() !== 1) begin errors++; $display("[TB] FAIL rmw_fifo: got %0d issues, required 1", iss_q.size()); end
        if (mem[320] !== 32'h55555555) begin errors++; $display("[TB] FAIL rmw_mem: got %h, required 55555555", mem[320]); end
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin errors++; $display("[TB] FAIL rmw_idle: read=%b write=%b, required 0 0", bus.mem_read, bus.mem_write); end
    endtask

    task automatic test_random();
        int e;
        bit          w;
        logic [9:0]  ix;
        logic [3:0]  m;
        logic [31:0] d;
        bit          ew [$];
        logic [31:0] ea [$];
        logic [31:0] ed [$];
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
        rand_delay = 1'b1;
        iss_q.delete();
        rsp_q.delete();
        for (int n = 0; n < 24; n++) begin
            w  = 1'($urandom_range(0, 1));
            ix = 10'(512 + $urandom_range(0, 7));
            m  = 4'($urandom_range(0, 15));
            d  = $urandom;
            ew.push_back(w);
            ea.push_back({20'h0, ix, 2'b00});
            if (w) begin
                ref_mem[ix] = merge(ref_mem[ix], d, m);
                ed.push_back(32'h0);
            end else begin
                ed.push_back(ref_mem[ix]);
            end
            send_req(w, {20'h0, ix, 2'($urandom_range(0, 3))}, m, d, e);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_rsp(24, 600);
        repeat (2) @(negedge clk);
        rand_delay = 1'b0;
        checks += 2;
        if (rsp_q.size() !== 24 || iss_q.size() !== 24) begin errors++; $display("[TB] FAIL rand_count: got %0d issues %0d responses, required 24", iss_q.size(), rsp_q.size()); end
        if (timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL rand_timeout: got %b, required 0", timeout_err); end
        for (int i = 0; i < 24 && i < rsp_q.size() && i < iss_q.size(); i++) begin
            checks += 2;
            if (iss_q[i].write !== ew[i] || iss_q[i].addr !== ea[i]) begin
                errors++;
                $display("[TB] FAIL rand_issue%0d: got w%b a=%h, required w%b a=%h", i, iss_q[i].write, iss_q[i].addr, ew[i], ea[i]);
            end
            if (rsp_q[i].write !== ew[i] || rsp_q[i].rdata !== ed[i]) begin
                errors++;
                $display("[TB] FAIL rand_rsp%0d: got w%b d=%h, required w%b d=%h", i, rsp_q[i].write, rsp_q[i].rdata, ew[i], ed[i]);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_wmask = 4'h0;
        bus.req_wdata = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        @(negedge clk);
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_stall();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so that a hung scenario still reports
    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: still running at %0t, required finish earlier", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Requester-side driver for the team's mem_itf read/write/resp memory protocol.
- Accepts word requests from a core-side valid/ready port into a small FIFO. Issues them to memory one at a time, holding every bus signal stable until resp. Returns a single-cycle response pulse to the core.
- Sits between the CPU/cache datapath and the mem_itf memory model or controller.
- Guarantees protocol cleanliness: no X on controls, no simultaneous read/write, no early deassert, no address/mask change mid-transaction.

Parameters:
- QUEUE_DEPTH, 2, request FIFO entries; power of two, at least 1.
- TIMEOUT, 64, cycles waiting for mem_resp before timeout_err sets; 0 disables the check.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  FIFO can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  32  byte address; bits [1:0] ignored
- req_wmask  in  4  byte enables; used for writes only
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_write  out  1  completed transaction was a write
- rsp_rdata  out  32  read data; 0 for writes
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wmask  out  4  byte mask; 0 during reads
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid while mem_resp = 1
- mem_resp  in  1  memory completion
- timeout_err  out  1  sticky timeout flag

Behaviour:
- Reset values:
  - All outputs 0 except req_ready = 1.
  - FIFO emptied; FSM to IDLE; timeout counter 0; timeout_err cleared.
- Reset mid-transaction: mem_read/mem_write drop the cycle after the reset edge. No response is produced. Queued requests are discarded.
- Request port:
  - A request is accepted on a rising edge with req_valid && req_ready.
  - req_ready = (count < QUEUE_DEPTH), computed from the registered count only. A same-cycle pop does not free a slot.
- FSM: IDLE -> BUSY -> GAP.
  - IDLE: if the FIFO is non-empty, pop the head at the edge and go to BUSY.
    - Load mem_addr = {addr[31:2], 2'b00}.
    - Read: mem_read = 1, mem_wmask = 0.
    - Write: mem_write = 1, mem_wmask = req_wmask, mem_wdata = req_wdata.
    - All bus outputs are registered.
  - BUSY: hold mem_read/mem_write, mem_addr, mem_wmask and mem_wdata unchanged until the edge at which mem_resp is sampled 1. Write data must still be valid through the cycle resp is high.
    - At that edge: deassert the strobe and clear mem_wmask to 0.
    - Capture rsp_rdata = mem_rdata for reads, 0 for writes. Set rsp_write; pulse rsp_valid for exactly one cycle. No backpressure on the response.
    - Go to GAP.
  - GAP: the strobe stays low one full cycle (mandatory idle between transactions), then behave as IDLE. Popping from GAP is allowed at its exit edge.
  - mem_resp while in IDLE or GAP is ignored.
- Invariants:
  - mem_read and mem_write are never 1 together.
  - At most one outstanding transaction.
  - FIFO order is preserved.
- Latency:
  - Request accepted at edge E into an empty FIFO in IDLE: strobe high after E+1.
  - With a 3-cycle-delay memory: mem_resp sampled at E+6, rsp_valid high during cycle E+6..E+7.
  - Next queued strobe rises after E+7.
- Timeout:
  - The counter increments each BUSY cycle without resp and clears on leaving BUSY.
  - When it reaches TIMEOUT, timeout_err sets and stays set until rst.
  - The transaction keeps being held: no abort, since an abort would violate the protocol.
- Simultaneous accept and pop on the same edge: count unchanged. Accepting into an empty FIFO while in IDLE does not bypass; the issue happens the next edge.
- FIFO pointers wrap modulo QUEUE_DEPTH.

Test Plan:
- Read: memory word 0x100 = 0xDEADBEEF; request read 0x102 at E -> mem_read high from E+1 with mem_addr = 0x100 and mem_wmask = 0; rsp_valid one cycle with rsp_rdata = 0xDEADBEEF, rsp_write = 0.
- Write then read: write 0x200, mask 4'b0101, data 0xAABBCCDD over word 0x11223344; then read 0x200 -> rsp_rdata = 0x11BB33DD; no memory error flagged; at least one strobe-low cycle between the two transactions.
- Back-pressure: 4 requests presented back to back with QUEUE_DEPTH = 2 -> req_ready low once 2 entries are queued; all 4 complete in order; the read/write and address sequence matches the issue order.
- Stall: memory never asserts resp, TIMEOUT = 8 -> timeout_err rises after 8 BUSY cycles; mem_read and mem_addr remain stable; the flag persists.
- Reset mid-write: rst asserted 2 cycles into BUSY -> mem_write = 0 and req_ready = 1 next cycle; FIFO empty; no rsp_valid; memory contents unchanged.
- Protocol monitor over random traffic: never read && write, no X on controls after reset, strobe and address stable until resp.
